// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams registers First..Last (wrapping) from a register file as valid/ready beats
// Ports: clk, Reset (async, active low); Start/First/Last request a dump, Abort cancels it;
// RF_Addr/RF_Ren/RF_Data form the one-cycle-latency register-file read port;
// Out_Data/Out_Idx/Out_Valid/Out_Ready carry the beats; Busy is high outside IDLE, Done pulses on completion.
module regfile_dump_reader #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] First,
  input  logic [AW-1:0] Last,
  input  logic          Abort,
  output logic [AW-1:0] RF_Addr,
  output logic          RF_Ren,
  input  logic [DW-1:0] RF_Data,
  output logic [DW-1:0] Out_Data,
  output logic [AW-1:0] Out_Idx,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Busy,
  output logic          Done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;
  state_t state;
  logic [AW-1:0] idx, last_idx;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  // RF_Ren/RF_Addr are loaded on entry to FETCH so the strobe lines up with the FETCH cycle
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      last_idx  <= '0;
      RF_Addr   <= '0;
      RF_Ren    <= 1'b0;
      Out_Data  <= '0;
      Out_Idx   <= '0;
      Out_Valid <= 1'b0;
    end else if (Abort) begin
      state     <= IDLE;
      RF_Ren    <= 1'b0;
      Out_Valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (Start) begin
            state    <= FETCH;
            idx      <= First;
            last_idx <= Last;
            RF_Addr  <= First;
            RF_Ren   <= 1'b1;
          end
        FETCH: begin
          state  <= WAIT;
          RF_Ren <= 1'b0;
        end
        WAIT: begin
          state     <= SEND;
          Out_Data  <= RF_Data;
          Out_Idx   <= idx;
          Out_Valid <= 1'b1;
        end
        SEND:
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            state     <= idx == last_idx ? DONE : FETCH;
            if (idx != last_idx) begin
              idx     <= idx + 1'b1;
              RF_Addr <= idx + 1'b1;
              RF_Ren  <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  First = '0;
  logic [2:0]  Last = '0;
  logic        Abort = 1'b0;
  logic [2:0]  RF_Addr;
  logic        RF_Ren;
  logic [15:0] RF_Data;
  logic [15:0] Out_Data;
  logic [2:0]  Out_Idx;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic        Busy;
  logic        Done;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int nbeats, ndone;
  logic [2:0]  bidx [8];
  logic [15:0] bdat [8];
  int eidx [4] = '{6, 7, 0, 1};
  regfile_dump_reader #(.DW(16), .AW(3)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .First(First), .Last(Last), .Abort(Abort),
    .RF_Addr(RF_Addr), .RF_Ren(RF_Ren), .RF_Data(RF_Data),
    .Out_Data(Out_Data), .Out_Idx(Out_Idx), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Busy(Busy), .Done(Done)
  );
  always #5 clk = ~clk;
  // register file holds r[i] = 16'h1000 + i; data is garbage except the cycle after a read
  always_ff @(posedge clk) RF_Data <= RF_Ren ? 16'h1000 + {13'd0, RF_Addr} : 16'hdead;
  always @(negedge clk) if (Out_Valid && RF_Ren) overlap++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic collect(input int budget);
    nbeats = 0;
    ndone = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (Out_Valid && Out_Ready && nbeats < 8) begin
        bidx[nbeats] = Out_Idx;
        bdat[nbeats] = Out_Data;
        nbeats++;
      end
      if (Done) ndone++;
      if (!Busy) break;
    end
  endtask
  initial begin
    #2 Reset = 1'b0;
    #1;
    chk("rst_ren", {31'd0, RF_Ren}, 0);
    chk("rst_addr", {29'd0, RF_Addr}, 0);
    chk("rst_valid", {31'd0, Out_Valid}, 0);
    chk("rst_data", {16'd0, Out_Data}, 0);
    chk("rst_busy", {30'd0, Busy, Done}, 0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    // basic dump 2..4 with exact latency
    Start = 1'b1; First = 3'd2; Last = 3'd4; Out_Ready = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("k1_ren", {31'd0, RF_Ren}, 1);
    chk("k1_addr", {29'd0, RF_Addr}, 2);
    chk("k1_busy_valid", {30'd0, Busy, Out_Valid}, 2);
    @(negedge clk);
    chk("k2_ren_valid", {30'd0, RF_Ren, Out_Valid}, 0);
    chk("k2_addr_hold", {29'd0, RF_Addr}, 2);
    @(negedge clk);
    chk("k3_valid", {31'd0, Out_Valid}, 1);
    chk("k3_beat", {13'd0, Out_Idx, Out_Data}, {13'd0, 3'd2, 16'h1002});
    @(negedge clk);
    chk("k4_fetch", {28'd0, RF_Ren, RF_Addr}, {28'd0, 1'b1, 3'd3});
    chk("k4_valid", {31'd0, Out_Valid}, 0);
    repeat (2) @(negedge clk);
    chk("k6_beat", {12'd0, Out_Valid, Out_Idx, Out_Data}, {12'd0, 1'b1, 3'd3, 16'h1003});
    repeat (3) @(negedge clk);
    chk("k9_beat", {12'd0, Out_Valid, Out_Idx, Out_Data}, {12'd0, 1'b1, 3'd4, 16'h1004});
    @(negedge clk);
    chk("k10_done", {29'd0, Done, Busy, Out_Valid}, {29'd0, 3'b110});
    @(negedge clk);
    chk("k11_idle", {30'd0, Done, Busy}, 0);
    // wrapping dump 6..1 with Start re-asserted while busy
    Start = 1'b1; First = 3'd6; Last = 3'd1;
    @(negedge clk);
    First = 3'd3; Last = 3'd3;
    collect(40);
    Start = 1'b0;
    chk("wrap_nbeats", nbeats, 4);
    chk("wrap_ndone", ndone, 1);
    chk("wrap_busy", {31'd0, Busy}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_idx", {29'd0, bidx[i]}, eidx[i]);
      chk("wrap_data", {16'd0, bdat[i]}, 32'h1000 + eidx[i]);
    end
    @(negedge clk);
    chk("wrap_no_restart", {31'd0, Busy}, 0);
    // single register with back-pressure
    Start = 1'b1; First = 3'd5; Last = 3'd5; Out_Ready = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {11'd0, Done, Out_Valid, Out_Idx, Out_Data}, {11'd0, 1'b0, 1'b1, 3'd5, 16'h1005});
      if (i < 9) @(negedge clk);
    end
    Out_Ready = 1'b1;
    @(negedge clk);
    chk("bp_done", {30'd0, Done, Out_Valid}, 2);
    @(negedge clk);
    chk("bp_idle", {30'd0, Done, Busy}, 0);
    // abort concurrent with handshake in SEND
    Start = 1'b1; First = 3'd0; Last = 3'd7; Out_Ready = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ab_send", {31'd0, Out_Valid}, 1);
    Abort = 1'b1; Out_Ready = 1'b1;
    @(negedge clk);
    Abort = 1'b0; Out_Ready = 1'b0;
    chk("ab_idle", {28'd0, Busy, Out_Valid, RF_Ren, Done}, 0);
    @(negedge clk);
    chk("ab_nodone", {30'd0, Busy, Done}, 0);
    // abort beats start in IDLE
    Start = 1'b1; Abort = 1'b1;
    @(negedge clk);
    Start = 1'b0; Abort = 1'b0;
    chk("ab_start", {30'd0, Busy, RF_Ren}, 0);
    // async reset mid-WAIT, then a 0..0 dump
    Start = 1'b1; First = 3'd3; Last = 3'd6; Out_Ready = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #1 Reset = 1'b0;
    #1;
    chk("ar_outs", {9'd0, RF_Ren, RF_Addr, Out_Valid, Out_Data, Out_Idx, Busy, Done}, 0);
    @(negedge clk);
    Reset = 1'b1; Start = 1'b1; First = 3'd0; Last = 3'd0;
    @(negedge clk);
    Start = 1'b0;
    chk("ar_first_start", {28'd0, RF_Ren, RF_Addr}, {28'd0, 1'b1, 3'd0});
    collect(20);
    chk("ar_nbeats", nbeats, 1);
    chk("ar_beat", {13'd0, bidx[0], bdat[0]}, {13'd0, 3'd0, 16'h1000});
    chk("ar_ndone", ndone, 1);
    chk("ar_busy", {31'd0, Busy}, 0);
    chk("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
